t_ff_count_ctrl: RTL and testbench



---
 rtl/t_ff_count_ctrl_pkg.sv | 12 +
 rtl/t_ff_bank.sv | 28 ++
 rtl/t_ff_count_ctrl.sv | 139 +++++++++++++
 tb/tb_t_ff_count_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/t_ff_count_ctrl_pkg.sv
// Shared constants for the T flip-flop mod-N count sequencer.
// State encoding and default bank/wrap-counter widths.
package t_ff_count_ctrl_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int WRAP_W_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/t_ff_bank.sv
// Bank of WIDTH toggle flip-flops: q flips wherever t_vec is set.
// Provides true and inverted outputs.
module t_ff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             c,
  input  logic             rst,
  input  logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q1
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q ^ t_vec;
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign q1 = ~q_q;

endmodule

// File: rtl/t_ff_count_ctrl.sv
// Drives a T flip-flop bank as a mod-N up/down counter that runs
// for a programmed number of wraps, with start/stop handshake.
module t_ff_count_ctrl
  import t_ff_count_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              c,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              up,
  input  logic [WIDTH-1:0]  mod_val,
  input  logic [WRAP_W-1:0] n_wraps,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q1,
  output logic [WIDTH-1:0]  t_vec,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [WIDTH-1:0]  ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]  TWO  = WIDTH'(2);
  localparam logic [WRAP_W-1:0] WONE = WRAP_W'(1);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  mod_q, mod_d;
  logic              up_q, up_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic [WRAP_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;

  logic              start_ok;
  logic              start_bad;
  logic [WIDTH-1:0]  lim;
  logic [WIDTH-1:0]  nxt;
  logic              wrap;
  logic [WRAP_W-1:0] wcnt_inc;
  logic              last;

  assign start_ok  = start & ~stop & (mod_val >= TWO);
  assign start_bad = start & ~stop & (mod_val < TWO);

  // Next count; an out-of-range value restarts from zero when counting up.
  always_comb begin
    lim  = mod_q - ONE;
    nxt  = '0;
    wrap = 1'b0;
    if (up_q) begin
      nxt  = (q >= lim) ? '0 : q + ONE;
      wrap = (q == lim);
    end else begin
      nxt  = (q == '0) ? lim : q - ONE;
      wrap = (q == '0);
    end
    wcnt_inc = (&wcnt_q) ? wcnt_q : wcnt_q + WONE;
    last = wrap && (wraps_q != '0) && (wcnt_inc == wraps_q);
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mod_q   <= '0;
      up_q    <= 1'b0;
      wraps_q <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      up_q    <= up_d;
      wraps_q <= wraps_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    up_d    = up_q;
    wraps_d = wraps_q;
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        err_d = start_bad;
        if (start_ok) begin
          state_d = ST_RUN;
          mod_d   = mod_val;
          up_d    = up;
          wraps_d = n_wraps;
          wcnt_d  = '0;
        end
      end
      ST_RUN: begin
        // Stop beats a simultaneous final wrap.
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          if (wrap) wcnt_d = wcnt_inc;
          if (last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    t_vec = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok)
          t_vec = q ^ (up ? '0 : mod_val - ONE);
      end
      ST_RUN: begin
        if (!stop) t_vec = q ^ nxt;
      end
      default: t_vec = '0;
    endcase
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
    err  = err_q;
  end

  t_ff_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .c    (c),
    .rst  (rst),
    .t_vec(t_vec),
    .q    (q),
    .q1   (q1)
  );

endmodule

// File: tb/tb_t_ff_count_ctrl.sv
// Scoreboard bench for t_ff_count_ctrl: expected per-cycle bank
// state is queued when a run starts and popped as the DUT advances.
module tb_t_ff_count_ctrl;

  logic       c = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       up = 1'b0;
  logic [3:0] mod_val = 4'd0;
  logic [3:0] n_wraps = 4'd0;
  logic [3:0] q, q1, t_vec;
  logic       busy, done, err;

  typedef struct packed {
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic [3:0] tv;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [3:0] mq = 4'd0;

  t_ff_count_ctrl #(.WIDTH(4), .WRAP_W(4)) dut (
    .c(c), .rst(rst), .start(start), .stop(stop), .up(up),
    .mod_val(mod_val), .n_wraps(n_wraps), .q(q), .q1(q1),
    .t_vec(t_vec), .busy(busy), .done(done), .err(err)
  );

  always #5 c = ~c;

  always @(negedge c) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({q, q1, busy, done, err} !== {4'h0, 4'hF, 3'b000}) begin
      errors++;
      $display("FAIL reset_async got %h/%h b%b d%b e%b want 0/f b0 d0 e0",
               q, q1, busy, done, err);
    end
    #4 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({t_vec, q, busy} !== {4'h0, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold[%0d] got tv=%h q=%h b=%b want 0 0 0",
                 i, t_vec, q, busy);
      end
    end
    mq = 4'd0;
  endtask

  // Builds the expected trace from a plain behavioural counter model.
  task automatic test_count(input logic u, input logic [3:0] m,
                            input logic [3:0] nw);
    logic [3:0] init, cq, nx;
    logic       wr;
    int         wc;
    exp_t       e;
    init = u ? 4'd0 : m - 4'd1;
    cq = init;
    wc = 0;
    for (int i = 0; i < 200; i++) begin
      if (u) begin
        nx = (cq >= m - 4'd1) ? 4'd0 : cq + 4'd1;
        wr = (cq == m - 4'd1);
      end else begin
        nx = (cq == 4'd0) ? m - 4'd1 : cq - 4'd1;
        wr = (cq == 4'd0);
      end
      sb.push_back('{q: cq, busy: 1'b1, done: 1'b0, tv: cq ^ nx});
      if (wr && wc < 15) wc++;
      cq = nx;
      if (nw != 0 && wr && wc == int'(nw)) begin
        sb.push_back('{q: cq, busy: 1'b1, done: 1'b1, tv: 4'h0});
        sb.push_back('{q: cq, busy: 1'b0, done: 1'b0, tv: 4'h0});
        break;
      end
    end
    up = u; mod_val = m; n_wraps = nw; start = 1'b1;
    #1;
    checks++;
    if (t_vec !== (mq ^ init)) begin
      errors++;
      $display("FAIL start_tvec got %h want %h", t_vec, mq ^ init);
    end
    tick();
    start = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({q, q1, busy, done, t_vec} !== {e.q, ~e.q, e.busy, e.done, e.tv}) begin
        errors++;
        $display("FAIL count_u%0b_m%0d got q=%h q1=%h b=%b d=%b tv=%h want q=%h q1=%h b=%b d=%b tv=%h",
                 u, m, q, q1, busy, done, t_vec, e.q, ~e.q, e.busy, e.done, e.tv);
      end
      if (sb.size() > 0) tick();
    end
    mq = cq;
  endtask

  task automatic test_stop();
    int d0;
    d0 = done_cnt;
    up = 1'b1; mod_val = 4'd10; n_wraps = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    checks++;
    if ({q, busy} !== {4'd7, 1'b1}) begin
      errors++;
      $display("FAIL stop_pre got q=%h b=%b want 7 1", q, busy);
    end
    stop = 1'b1;
    #1;
    checks++;
    if (t_vec !== 4'h0) begin
      errors++;
      $display("FAIL stop_tvec got %h want 0", t_vec);
    end
    tick();
    stop = 1'b0;
    checks++;
    if ({q, busy, done} !== {4'd7, 2'b00}) begin
      errors++;
      $display("FAIL stop_hold got q=%h b=%b d=%b want 7 0 0", q, busy, done);
    end
    n_wraps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    checks++;
    if ({q, busy} !== {4'd9, 1'b1}) begin
      errors++;
      $display("FAIL coll_pre got q=%h b=%b want 9 1", q, busy);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({q, busy, done} !== {4'd9, 2'b00}) begin
      errors++;
      $display("FAIL coll_hold got q=%h b=%b d=%b want 9 0 0", q, busy, done);
    end
    repeat (2) tick();
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL stop_no_done got %0d pulses want 0", done_cnt - d0);
    end
    mq = 4'd9;
  endtask

  task automatic test_bad_start();
    mod_val = 4'd1; up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({err, busy, q} !== {2'b10, mq}) begin
      errors++;
      $display("FAIL bad_err got e=%b b=%b q=%h want 1 0 %h", err, busy, q, mq);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL bad_err_pulse got %b want 0", err);
    end
    mod_val = 4'd5; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({err, busy, q} !== {2'b00, mq}) begin
      errors++;
      $display("FAIL start_stop got e=%b b=%b q=%h want 0 0 %h", err, busy, q, mq);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    up = 1'b1; mod_val = 4'd10; n_wraps = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if (q !== 4'd3) begin
      errors++;
      $display("FAIL arst_pre got q=%h want 3", q);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({q, q1, busy} !== {4'h0, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL arst_now got q=%h q1=%h b=%b want 0 f 0", q, q1, busy);
    end
    #2 rst = 1'b0;
    d0 = done_cnt;
    repeat (3) tick();
    checks++;
    if ({done_cnt, q, busy} !== {d0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL arst_after got pulses=%0d q=%h b=%b want 0 0 0",
               done_cnt - d0, q, busy);
    end
    mq = 4'd0;
  endtask

  initial begin
    test_reset();
    test_count(1'b1, 4'd5, 4'd1);
    test_count(1'b0, 4'd3, 4'd2);
    test_stop();
    test_bad_start();
    test_async_reset();
    test_count(1'b1, 4'd5, 4'd1);
    test_count(1'b0, 4'd2, 4'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
